// File: rtl/fb_fill_sched_pkg.sv
// Shared constants for the frame-buffer fill scheduler: screen geometry,
// address widths, FSM encodings and the clip helper.
package fb_fill_sched_pkg;

    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;
    localparam int COLOR_W_DEF = 12;
    localparam int X_W         = 10;
    localparam int Y_W         = 9;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Last covered coordinate of a span clipped to limit; 11 bits so start+len cannot wrap.
    function automatic logic [10:0] clip_last(input logic [10:0] start,
                                              input logic [10:0] len,
                                              input logic [10:0] limit);
        logic [10:0] stop;
        stop = start + len;
        if (stop > limit) begin
            stop = limit;
        end
        return stop - 11'd1;
    endfunction

endpackage

// File: rtl/fb_fill_sched_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last is chosen.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_reg;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_reg ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last_reg <= grant[1];
        end
    end

endmodule

// File: rtl/fb_fill_sched.sv
// Frame-buffer write-port scheduler: arbitrates two rectangle painters, clips the
// winner to the screen and streams it into the buffer at two cycles per pixel.
module fb_fill_sched
    import fb_fill_sched_pkg::*;
#(
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int COLOR_W = COLOR_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req,
    input  logic [2*X_W-1:0]       req_x,
    input  logic [2*Y_W-1:0]       req_y,
    input  logic [2*X_W-1:0]       req_w,
    input  logic [2*Y_W-1:0]       req_h,
    input  logic [2*COLOR_W-1:0]   req_color,
    output logic [1:0]             gnt,
    output logic                   done,
    output logic                   done_id,
    output logic                   busy,
    output logic                   Load,
    output logic [Y_W-1:0]         HAddr,
    output logic [X_W-1:0]         LAddr,
    output logic [COLOR_W-1:0]     Data
);

    logic [X_W-1:0]     fx [2];
    logic [Y_W-1:0]     fy [2];
    logic [X_W-1:0]     fw [2];
    logic [Y_W-1:0]     fh [2];
    logic [COLOR_W-1:0] fc [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fields
            assign fx[gi] = req_x[X_W*gi +: X_W];
            assign fy[gi] = req_y[Y_W*gi +: Y_W];
            assign fw[gi] = req_w[X_W*gi +: X_W];
            assign fh[gi] = req_h[Y_W*gi +: Y_W];
            assign fc[gi] = req_color[COLOR_W*gi +: COLOR_W];
        end
    endgenerate

    logic [1:0]         state_reg, state_next;
    logic [1:0]         arb_grant;
    logic               win;
    logic [X_W-1:0]     sx, sw;
    logic [Y_W-1:0]     sy, sh;
    logic [COLOR_W-1:0] sc;
    logic [10:0]        x_end_c, y_end_c;
    logic               empty_c;

    logic [X_W-1:0]     x_start_reg, col_reg;
    logic [Y_W-1:0]     row_reg;
    logic [10:0]        x_end_reg, y_end_reg;
    logic [COLOR_W-1:0] color_reg;
    logic               id_reg;
    logic               last_col, last_row;

    logic [1:0]         gnt_reg;
    logic               done_reg, done_id_reg, busy_reg, load_reg;
    logic [Y_W-1:0]     haddr_reg;
    logic [X_W-1:0]     laddr_reg;
    logic [COLOR_W-1:0] data_reg;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (state_reg == ST_IDLE),
        .grant   (arb_grant)
    );

    assign win = arb_grant[1];
    assign sx  = fx[win];
    assign sy  = fy[win];
    assign sw  = fw[win];
    assign sh  = fh[win];
    assign sc  = fc[win];

    assign x_end_c = clip_last({1'b0, sx}, {1'b0, sw}, 11'(H_RES));
    assign y_end_c = clip_last({2'b0, sy}, {2'b0, sh}, 11'(V_RES));
    assign empty_c = (sw == '0) || (sh == '0) ||
                     ({1'b0, sx} >= 11'(H_RES)) || ({2'b0, sy} >= 11'(V_RES));

    assign last_col = ({1'b0, col_reg} == x_end_reg);
    assign last_row = ({2'b0, row_reg} == y_end_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (req != 2'b00) state_next = empty_c ? ST_DONE : ST_SETUP;
            ST_SETUP:  state_next = ST_STROBE;
            ST_STROBE: state_next = (last_col && last_row) ? ST_DONE : ST_SETUP;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            gnt_reg     <= 2'b00;
            done_reg    <= 1'b0;
            done_id_reg <= 1'b0;
            busy_reg    <= 1'b0;
            load_reg    <= 1'b0;
            haddr_reg   <= '0;
            laddr_reg   <= '0;
            data_reg    <= '0;
            x_start_reg <= '0;
            x_end_reg   <= '0;
            y_end_reg   <= '0;
            col_reg     <= '0;
            row_reg     <= '0;
            color_reg   <= '0;
            id_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != ST_IDLE);
            gnt_reg   <= 2'b00;
            done_reg  <= 1'b0;
            load_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        gnt_reg     <= arb_grant;
                        id_reg      <= win;
                        x_start_reg <= sx;
                        x_end_reg   <= x_end_c;
                        y_end_reg   <= y_end_c;
                        col_reg     <= sx;
                        row_reg     <= sy;
                        color_reg   <= sc;
                    end
                end
                ST_SETUP: begin
                    haddr_reg <= row_reg;
                    laddr_reg <= col_reg;
                    data_reg  <= color_reg;
                end
                ST_STROBE: begin
                    // Counters move now; the address outputs only follow in SETUP,
                    // which keeps them stable across the Load rising edge.
                    load_reg <= 1'b1;
                    if (last_col) begin
                        col_reg <= x_start_reg;
                        if (!last_row) begin
                            row_reg <= row_reg + 1'b1;
                        end
                    end else begin
                        col_reg <= col_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_reg    <= 1'b1;
                    done_id_reg <= id_reg;
                end
                default: ;
            endcase
        end
    end

    assign gnt     = gnt_reg;
    assign done    = done_reg;
    assign done_id = done_id_reg;
    assign busy    = busy_reg;
    assign Load    = load_reg;
    assign HAddr   = haddr_reg;
    assign LAddr   = laddr_reg;
    assign Data    = data_reg;

endmodule
